// File: rtl/spi_dac_receiver.sv
// spi_dac_receiver
//   SPI responder modelling the target of the DAC write path. A WIDTH-bit,
//   LSB-first word framed by CSn is shifted in on SCK rising edges. A good
//   frame is latched into the input register, and an LDAc falling edge copies
//   the input register into the output (DAC) register. All SPI pins are
//   asynchronous to clk and are oversampled through synchronizers.
//
// Ports
//   clk        system clock, pin oversampling clock
//   rst_l      asynchronous active-low reset
//   SCK        SPI clock from controller (async)
//   SDI        serial data from controller, LSB first (async)
//   CSn        frame select, active low (async)
//   LDAc       load DAC, active low, falling-edge triggered (async)
//   CLRn       clear, active low, level sensitive (async, sampled)
//   SDO        readback of the input register held at frame start, LSB first
//   dac_code   output (DAC) register
//   input_word input register (last good frame)
//   word_valid one-clk pulse: good frame latched into input_word
//   frame_err  one-clk pulse: frame ended with bit count != WIDTH
//   dac_update one-clk pulse: dac_code loaded
//   busy       high while a frame is open
module spi_dac_receiver #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             SCK,
    input  logic             SDI,
    input  logic             CSn,
    input  logic             LDAc,
    input  logic             CLRn,
    output logic             SDO,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] input_word,
    output logic             word_valid,
    output logic             frame_err,
    output logic             dac_update,
    output logic             busy
);

    localparam int              CNT_W   = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(WIDTH);
    // Level-only pins: bit 0 = SDI (idles 0), bit 1 = CLRn (idles 1).
    localparam logic [1:0]      LVL_RST = 2'b10;

    // ------------------------------------------------------------------
    // Pin synchronizers. Edge pins {LDAc, CSn, SCK} get a history flop
    // after the synchronizer; SDI and CLRn are only used as levels.
    // ------------------------------------------------------------------
    logic [2:0] edge_raw;
    logic [2:0] edge_sync;
    logic [2:0] edge_hist;
    logic [1:0] lvl_raw;
    logic [1:0] lvl_sync;

    assign edge_raw = {LDAc, CSn, SCK};
    assign lvl_raw  = {CLRn, SDI};

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge_sync
        logic [SYNC_STAGES-1:0] stage_reg;
        logic                   hist_reg;
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                stage_reg <= '1;
                hist_reg  <= 1'b1;
            end else begin
                stage_reg <= {stage_reg[SYNC_STAGES-2:0], edge_raw[gi]};
                hist_reg  <= stage_reg[SYNC_STAGES-1];
            end
        end
        assign edge_sync[gi] = stage_reg[SYNC_STAGES-1];
        assign edge_hist[gi] = hist_reg;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl_sync
        logic [SYNC_STAGES-1:0] stage_reg;
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                stage_reg <= {SYNC_STAGES{LVL_RST[gi]}};
            end else begin
                stage_reg <= {stage_reg[SYNC_STAGES-2:0], lvl_raw[gi]};
            end
        end
        assign lvl_sync[gi] = stage_reg[SYNC_STAGES-1];
    end

    logic sck_rise, sck_fall, csn_rise, csn_fall, ldac_fall;
    logic sdi_sync, clr_active;

    assign sck_rise   =  edge_sync[0] & ~edge_hist[0];
    assign sck_fall   = ~edge_sync[0] &  edge_hist[0];
    assign csn_rise   =  edge_sync[1] & ~edge_hist[1];
    assign csn_fall   = ~edge_sync[1] &  edge_hist[1];
    assign ldac_fall  = ~edge_sync[2] &  edge_hist[2];
    assign sdi_sync   = lvl_sync[0];
    assign clr_active = ~lvl_sync[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // CSn rising in IDLE and CSn falling in CHECK are deliberately dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (csn_fall) state_next = ST_SHIFT;
            ST_SHIFT: if (csn_rise) state_next = ST_CHECK;
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    logic [CNT_W-1:0] bit_cnt_reg;
    logic             frame_start, sample_en, sdo_step, frame_end;
    logic             check_good, check_bad;

    // While CLRn is held low the CHECK result is thrown away silently.
    always_comb begin
        busy        = (state_reg == ST_SHIFT);
        frame_start = (state_reg == ST_IDLE)  && csn_fall;
        sample_en   = (state_reg == ST_SHIFT) && sck_rise;
        sdo_step    = (state_reg == ST_SHIFT) && sck_fall;
        frame_end   = (state_reg == ST_SHIFT) && csn_rise;
        check_good  = (state_reg == ST_CHECK) && (bit_cnt_reg == CNT_OK) && !clr_active;
        check_bad   = (state_reg == ST_CHECK) && (bit_cnt_reg != CNT_OK) && !clr_active;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] sdo_shift_reg;

    // SDO is bit 0 of the readback shifter, which is cleared outside SHIFT.
    assign SDO = sdo_shift_reg[0];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            sdo_shift_reg <= '0;
            input_word    <= '0;
            dac_code      <= '0;
            word_valid    <= 1'b0;
            frame_err     <= 1'b0;
            dac_update    <= 1'b0;
        end else begin
            // Receive shifter: first bit in ends up in bit 0 after WIDTH
            // shifts. The counter saturates so over-long frames never alias
            // back to a legal count.
            if (frame_start) begin
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
            end else if (sample_en) begin
                shift_reg <= {sdi_sync, shift_reg[WIDTH-1:1]};
                if (bit_cnt_reg != CNT_SAT) begin
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                end
            end

            if (frame_start) begin
                sdo_shift_reg <= input_word;
            end else if (frame_end) begin
                sdo_shift_reg <= '0;
            end else if (sdo_step) begin
                sdo_shift_reg <= {1'b0, sdo_shift_reg[WIDTH-1:1]};
            end

            if (clr_active) begin
                input_word <= '0;
            end else if (check_good) begin
                input_word <= shift_reg;
            end

            // An LDAc edge coinciding with the CHECK write forwards the new
            // word rather than the stale input register.
            if (clr_active) begin
                dac_code <= '0;
            end else if (ldac_fall) begin
                dac_code <= check_good ? shift_reg : input_word;
            end

            word_valid <= check_good;
            frame_err  <= check_bad;
            dac_update <= ldac_fall && !clr_active;
        end
    end

endmodule

// File: tb/tb_spi_dac_receiver.sv
module tb_spi_dac_receiver;

    localparam int WIDTH       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             SCK;
    logic             SDI;
    logic             CSn;
    logic             LDAc;
    logic             CLRn;
    logic             SDO;
    logic [WIDTH-1:0] dac_code;
    logic [WIDTH-1:0] input_word;
    logic             word_valid;
    logic             frame_err;
    logic             dac_update;
    logic             busy;

    int total  = 0;
    int bad    = 0;
    int wv_cnt = 0;
    int fe_cnt = 0;
    int du_cnt = 0;

    // Reference model: what the input and DAC registers should hold.
    logic [WIDTH-1:0] m_input = '0;
    logic [WIDTH-1:0] m_dac   = '0;

    always #5 clk = ~clk;

    spi_dac_receiver #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .SCK       (SCK),
        .SDI       (SDI),
        .CSn       (CSn),
        .LDAc      (LDAc),
        .CLRn      (CLRn),
        .SDO       (SDO),
        .dac_code  (dac_code),
        .input_word(input_word),
        .word_valid(word_valid),
        .frame_err (frame_err),
        .dac_update(dac_update),
        .busy      (busy)
    );

    // Pulse counters: each high cycle counts once.
    always @(negedge clk) begin
        if (word_valid === 1'b1) wv_cnt++;
        if (frame_err  === 1'b1) fe_cnt++;
        if (dac_update === 1'b1) du_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic open_frame();
        CSn = 1'b0;
        wait_clk(LAT - 1);
        chk("busy_before_sync", {31'd0, busy}, 0);
        wait_clk(1);
        chk("busy_rise", {31'd0, busy}, 1);
        wait_clk(1);
    endtask

    // Sends n bits LSB first, SCK low/high 3 clk each. SDO is sampled just
    // before each SCK rise and compared with the readback reference.
    task automatic shift_bits(input logic [63:0] bits, input int n, input logic [WIDTH-1:0] sdo_ref);
        for (int i = 0; i < n; i++) begin
            SDI = bits[i];
            wait_clk(3);
            if (i < WIDTH) chk($sformatf("sdo_bit%0d", i), {31'd0, SDO}, {31'd0, sdo_ref[i]});
            SCK = 1'b1;
            wait_clk(3);
            SCK = 1'b0;
        end
    endtask

    task automatic close_frame(input bit exp_good, input bit exp_err, input bit ldac_sync);
        wait_clk(3);
        CSn = 1'b1;
        wait_clk(1);
        if (ldac_sync) LDAc = 1'b0;   // lands on the CHECK cycle
        wait_clk(1);
        chk("busy_hold", {31'd0, busy}, 1);
        wait_clk(1);
        chk("busy_fall", {31'd0, busy}, 0);
        chk("sdo_idle", {31'd0, SDO}, 0);
        chk("wv_early", {31'd0, word_valid}, 0);
        LDAc = 1'b1;
        wait_clk(1);
        chk("wv_pulse", {31'd0, word_valid}, {31'd0, exp_good});
        chk("fe_pulse", {31'd0, frame_err}, {31'd0, exp_err});
        wait_clk(1);
        chk("wv_width", {31'd0, word_valid}, 0);
        wait_clk(3);
    endtask

    task automatic do_frame(input logic [63:0] bits, input int n, input bit ldac_sync);
        int wv0, fe0, du0;
        bit good, err, upd;
        wv0  = wv_cnt;
        fe0  = fe_cnt;
        du0  = du_cnt;
        good = (n == WIDTH) && (CLRn == 1'b1);
        err  = (n != WIDTH) && (CLRn == 1'b1);
        upd  = ldac_sync && (CLRn == 1'b1);
        open_frame();
        shift_bits(bits, n, m_input);
        close_frame(good, err, ldac_sync);
        if (good) m_input = bits[WIDTH-1:0];
        if (upd)  m_dac   = m_input;
        chk("input_word", {16'd0, input_word}, {16'd0, m_input});
        chk("dac_code", {16'd0, dac_code}, {16'd0, m_dac});
        chk("wv_count", wv_cnt - wv0, {31'd0, good});
        chk("fe_count", fe_cnt - fe0, {31'd0, err});
        chk("du_count", du_cnt - du0, {31'd0, upd});
        $display("frame n=%0d data=%0h -> input_word=%0h dac_code=%0h", n, bits[WIDTH-1:0], input_word, dac_code);
    endtask

    task automatic ldac_pulse();
        int du0;
        bit upd;
        du0 = du_cnt;
        upd = (CLRn == 1'b1);
        LDAc = 1'b0;
        wait_clk(LAT - 1);
        chk("du_early", {31'd0, dac_update}, 0);
        LDAc = 1'b1;
        wait_clk(1);
        chk("du_pulse", {31'd0, dac_update}, {31'd0, upd});
        wait_clk(1);
        chk("du_width", {31'd0, dac_update}, 0);
        wait_clk(3);
        if (upd) m_dac = m_input;
        chk("ldac_dac_code", {16'd0, dac_code}, {16'd0, m_dac});
        chk("ldac_du_count", du_cnt - du0, {31'd0, upd});
        $display("ldac -> dac_code=%0h", dac_code);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_sdo", {31'd0, SDO}, 0);
        chk("rst_dac_code", {16'd0, dac_code}, 0);
        chk("rst_input_word", {16'd0, input_word}, 0);
        chk("rst_wv", {31'd0, word_valid}, 0);
        chk("rst_fe", {31'd0, frame_err}, 0);
        chk("rst_du", {31'd0, dac_update}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        logic [63:0] rb;
        int          n;

        rst_l = 1'b0;
        SCK   = 1'b0;
        SDI   = 1'b0;
        CSn   = 1'b1;
        LDAc  = 1'b1;
        CLRn  = 1'b1;
        wait_clk(3);
        chk_reset_outputs();
        rst_l = 1'b1;
        wait_clk(5);

        // Two frames, no LDAc: readback of 0x1234 during the second frame.
        do_frame(64'h1234, WIDTH, 1'b0);
        do_frame(64'hFFFF, WIDTH, 1'b0);
        chk("no_ldac_dac_zero", {16'd0, dac_code}, 0);

        // Basic frame then LDAc.
        do_frame(64'hA5C3, WIDTH, 1'b0);
        ldac_pulse();

        // Short, long, double-length and wrap-length frames.
        do_frame(64'h0000_0000_0000_7ABC, WIDTH - 1, 1'b0);
        do_frame(64'h0000_0000_0001_5555, WIDTH + 1, 1'b0);
        do_frame(64'h0000_0000_CAFE_BABE, 2 * WIDTH, 1'b0);
        do_frame(64'h0000_1357_9BDF_2468, 3 * WIDTH, 1'b0);

        // LDAc edge coinciding with the CHECK write.
        do_frame(64'h0F0F, WIDTH, 1'b1);

        // CLRn held low: registers forced to 0, pulses suppressed.
        do_frame(64'h00FF, WIDTH, 1'b0);
        CLRn = 1'b0;
        wait_clk(LAT + 1);
        m_input = '0;
        m_dac   = '0;
        chk("clr_input_word", {16'd0, input_word}, 0);
        chk("clr_dac_code", {16'd0, dac_code}, 0);
        do_frame(64'h1111, WIDTH, 1'b0);
        ldac_pulse();
        CLRn = 1'b1;
        wait_clk(LAT + 1);

        // Reset in the middle of a frame.
        do_frame(64'h6C6C, WIDTH, 1'b1);
        open_frame();
        shift_bits(64'h0055, 7, m_input);
        rst_l = 1'b0;
        CSn   = 1'b1;
        SDI   = 1'b0;
        wait_clk(2);
        chk_reset_outputs();
        rst_l = 1'b1;
        m_input = '0;
        m_dac   = '0;
        wait_clk(5);
        do_frame(64'hBEEF, WIDTH, 1'b0);
        ldac_pulse();

        // Randomized frames against the model.
        for (int k = 0; k < 12; k++) begin
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0, 1:    n = WIDTH;
                2:       n = ($urandom_range(0, 1) == 0) ? WIDTH - 1 : WIDTH + 1;
                default: n = $urandom_range(1, 2 * WIDTH);
            endcase
            do_frame(rb, n, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) ldac_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
